controle_contador_7_bits: RTL

- FSM controller that sequences the 7-bit synchronous up/down counter with asynchronous parallel load (counter ports: load, e_load, enable, up_down, q).
- Captures preset, limit and direction on a start command, loads the counter, and enables counting until q equals the limit.
- Supports pause/resume and abort.
- Reports busy, a one-cycle done pulse, and its state. Sits between the user-facing panel logic and the counter instance.

---
 rtl/controle_contador_7_bits_pkg.sv | 17 +
 rtl/controle_contador_7_bits_if.sv | 39 +++
 rtl/controle_contador_7_bits_comparador.sv | 15 +
 rtl/controle_contador_7_bits.sv | 106 ++++++++++
 4 files changed

// File: rtl/controle_contador_7_bits_pkg.sv
// Shared definitions for the 7-bit counter controller.
//   W         : counter width in bits (must match the counter instance)
//   cnt_t     : counter-width value type
//   ST_*      : controller state encoding, also exposed on the state output
package controle_contador_7_bits_pkg;

    localparam int W = 7;

    typedef logic [W-1:0] cnt_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/controle_contador_7_bits_if.sv
// Bundle between the panel logic, the controller and the 7-bit counter.
//   panel -> controller : start, stop, pause, dir_up, preset, limit
//   counter -> controller: cnt_q
//   controller -> counter: ctr_load, ctr_e_load, ctr_enable, ctr_up_down
//   controller -> panel : busy, done, state
// Handshake: there is no valid/ready pair. start is a level that is
// sampled on every rising clk edge while the controller is idle, and
// ignored otherwise. done is a single-cycle pulse and busy is a plain level.
// modport master : the controller side
// modport slave  : the environment (panel + counter) side
interface controle_contador_7_bits_if;
    import controle_contador_7_bits_pkg::*;

    logic       start;
    logic       stop;
    logic       pause;
    logic       dir_up;
    cnt_t       preset;
    cnt_t       limit;
    cnt_t       cnt_q;
    logic       ctr_load;
    cnt_t       ctr_e_load;
    logic       ctr_enable;
    logic       ctr_up_down;
    logic       busy;
    logic       done;
    logic [2:0] state;

    modport master (
        input  start, stop, pause, dir_up, preset, limit, cnt_q,
        output ctr_load, ctr_e_load, ctr_enable, ctr_up_down, busy, done, state
    );

    modport slave (
        output start, stop, pause, dir_up, preset, limit, cnt_q,
        input  ctr_load, ctr_e_load, ctr_enable, ctr_up_down, busy, done, state
    );

endinterface

// File: rtl/controle_contador_7_bits_comparador.sv
// Equality comparator between the counter value and the captured limit.
//   a, b : values to compare
//   eq   : 1 when every bit pair matches
module controle_contador_7_bits_comparador
    import controle_contador_7_bits_pkg::*;
(
    input  cnt_t a,
    input  cnt_t b,
    output logic eq
);

    // Bitwise XNOR followed by an AND reduction.
    assign eq = &(a ~^ b);

endmodule

// File: rtl/controle_contador_7_bits.sv
// FSM controller that sequences a 7-bit up/down counter with async load.
// On start it captures preset, limit and direction, pulses the counter's
// load for one cycle, then enables counting until cnt_q equals the limit.
// Supports pause/resume (pause level) and abort (stop).
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : controle_contador_7_bits_if.master (panel, counter and status signals)
// Build option:
//   AUTO_RELOAD_EN : when defined, DONE returns to LOAD so the sequence
//                    repeats with the captured values; busy stays high in DONE.
module controle_contador_7_bits
    import controle_contador_7_bits_pkg::*;
(
    input logic                         clk,
    input logic                         rst,
    controle_contador_7_bits_if.master  bus
);

    logic [2:0] state_q, state_d;
    cnt_t       e_load_q, e_load_d;
    cnt_t       limit_q, limit_d;
    logic       up_down_q, up_down_d;
    logic       at_limit;

    controle_contador_7_bits_comparador u_cmp (
        .a  (bus.cnt_q),
        .b  (limit_q),
        .eq (at_limit)
    );

    always_comb begin
        state_d   = state_q;
        e_load_d  = e_load_q;
        limit_d   = limit_q;
        up_down_d = up_down_q;

        // stop beats everything else once a sequence is active.
        if (bus.stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d   = ST_LOAD;
                        e_load_d  = bus.preset;
                        limit_d   = bus.limit;
                        up_down_d = bus.dir_up;
                    end
                end
                ST_LOAD: state_d = ST_RUN;
                ST_RUN: begin
                    // Reaching the limit wins over a simultaneous pause.
                    if (at_limit) begin
                        state_d = ST_DONE;
                    end else if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (!bus.pause) begin
                        state_d = ST_RUN;
                    end
                end
`ifdef AUTO_RELOAD_EN
                ST_DONE: state_d = ST_LOAD;
`else
                ST_DONE: state_d = ST_IDLE;
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            e_load_q  <= '0;
            limit_q   <= '0;
            up_down_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            e_load_q  <= e_load_d;
            limit_q   <= limit_d;
            up_down_q <= up_down_d;
        end
    end

    // Outputs are decoded from registered state only, so ctr_load is
    // glitch-free and drops immediately with an async reset.
    assign bus.ctr_load    = (state_q == ST_LOAD);
    assign bus.ctr_e_load  = e_load_q;
    assign bus.ctr_up_down = up_down_q;
    // Gating with the live compare stops the counter exactly on the limit.
    assign bus.ctr_enable  = (state_q == ST_RUN) && !at_limit;
    assign bus.done        = (state_q == ST_DONE);
    assign bus.state       = state_q;
`ifdef AUTO_RELOAD_EN
    assign bus.busy        = (state_q == ST_LOAD) || (state_q == ST_RUN) ||
                             (state_q == ST_PAUSE) || (state_q == ST_DONE);
`else
    assign bus.busy        = (state_q == ST_LOAD) || (state_q == ST_RUN) ||
                             (state_q == ST_PAUSE);
`endif

endmodule
